// File: rtl/serializer.sv
// Parallel-to-serial transmitter for the CLK/DATA/LOAD/STOP board link.
// Words pass through a one-deep holding register into an MSB-first shifter.
module serializer #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] P_ADDR,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              P_ENA,
  output logic              P_RDY,
  output logic              TX_CLK,
  output logic              TX_DATA,
  output logic              TX_LOAD,
  output logic              TX_STOP,
  output logic              BUSY,
  output logic [1:0]        state_dbg
);

  localparam int F   = ADDR_W + DATA_W;
  localparam int BCW = $clog2(F + 1);
  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(F - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t         state_q, state_n;
  logic [DCW-1:0] div_q, div_n;
  logic           phase_q, phase_n;
  logic [BCW-1:0] bit_q, bit_n;
  logic [F-1:0]   shift_q, shift_n;
  logic [F-1:0]   hold_q, hold_n;
  logic           hold_valid_q, hold_valid_n;
  logic           tx_clk_q, tx_clk_n;
  logic           tx_load_q, tx_load_n;
  logic           tx_stop_q, tx_stop_n;
  logic           busy_q, busy_n;

  logic accept;
  logic tick;
  logic bit_end;
  logic take_hold;

  // Handshake: a word is taken on any CLK edge where P_ENA && P_RDY; P_RDY
  // depends only on the holding register, never on P_ENA, and a full holding
  // register is never overwritten.
  assign P_RDY     = !hold_valid_q;
  assign accept    = P_ENA && !hold_valid_q;
  assign tick      = (div_q == DIV_LAST);
  assign bit_end   = tick && phase_q;
  assign take_hold = hold_valid_q &&
                     ((state_q == S_IDLE) || ((state_q == S_GAP) && bit_end));

  assign TX_CLK    = tx_clk_q;
  assign TX_DATA   = shift_q[F-1];
  assign TX_LOAD   = tx_load_q;
  assign TX_STOP   = tx_stop_q;
  assign BUSY      = busy_q;
  assign state_dbg = state_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (hold_valid_q) state_n = S_SHIFT;
      S_SHIFT: if (bit_end && (bit_q == BIT_LAST)) state_n = S_LOAD;
      S_LOAD:  if (bit_end) state_n = S_GAP;
      S_GAP:   if (bit_end) state_n = hold_valid_q ? S_SHIFT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    div_n        = div_q;
    phase_n      = phase_q;
    bit_n        = bit_q;
    shift_n      = shift_q;
    hold_n       = hold_q;
    hold_valid_n = hold_valid_q;
    tx_stop_n    = tx_stop_q;

    if (accept) begin
      hold_n       = {P_ADDR, P_DATA};
      hold_valid_n = 1'b1;
    end

    if (state_q != S_IDLE) begin
      div_n = tick ? '0 : div_q + 1'b1;
      if (tick) phase_n = !phase_q;
    end

    // Zero-fill keeps TX_DATA low once the last bit has gone out.
    if ((state_q == S_SHIFT) && bit_end) begin
      shift_n = {shift_q[F-2:0], 1'b0};
      bit_n   = bit_q + 1'b1;
    end

    if (take_hold) begin
      shift_n      = hold_q;
      hold_valid_n = 1'b0;
      bit_n        = '0;
      div_n        = '0;
      phase_n      = 1'b0;
    end

    // STOP is decided once, on the LOAD entry edge, and held through LOAD.
    if ((state_q == S_SHIFT) && (state_n == S_LOAD))
      tx_stop_n = !hold_valid_q && !accept;
    else if (state_n != S_LOAD)
      tx_stop_n = 1'b0;

    tx_clk_n  = (state_n == S_SHIFT) && phase_n;
    tx_load_n = (state_n == S_LOAD);
    busy_n    = (state_n != S_IDLE) || hold_valid_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q        <= '0;
      phase_q      <= 1'b0;
      bit_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_clk_q     <= 1'b0;
      tx_load_q    <= 1'b0;
      tx_stop_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      div_q        <= div_n;
      phase_q      <= phase_n;
      bit_q        <= bit_n;
      shift_q      <= shift_n;
      hold_q       <= hold_n;
      hold_valid_q <= hold_valid_n;
      tx_clk_q     <= tx_clk_n;
      tx_load_q    <= tx_load_n;
      tx_stop_q    <= tx_stop_n;
      busy_q       <= busy_n;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: a pin-level frame monitor rebuilds each serial word and
// its timing, which is compared with the words the bench saw accepted.
`timescale 1ns/1ps
module tb_serializer;

  localparam int F = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with CLK_DIV = 4 ----------------
  logic [2:0]  p_addr4 = '0;
  logic [15:0] p_data4 = '0;
  logic        p_ena4  = 1'b0;
  logic        p_rdy4, tx_clk4, tx_data4, tx_load4, tx_stop4, busy4;
  logic [1:0]  st4;

  serializer #(.CLK_DIV(4), .ADDR_W(3), .DATA_W(16)) u_dut4 (
    .CLK(clk), .RST(rst), .P_ADDR(p_addr4), .P_DATA(p_data4), .P_ENA(p_ena4),
    .P_RDY(p_rdy4), .TX_CLK(tx_clk4), .TX_DATA(tx_data4), .TX_LOAD(tx_load4),
    .TX_STOP(tx_stop4), .BUSY(busy4), .state_dbg(st4)
  );

  // ---------------- DUT with CLK_DIV = 1 ----------------
  logic [2:0]  p_addr1 = '0;
  logic [15:0] p_data1 = '0;
  logic        p_ena1  = 1'b0;
  logic        p_rdy1, tx_clk1, tx_data1, tx_load1, tx_stop1, busy1;
  logic [1:0]  st1;

  serializer #(.CLK_DIV(1), .ADDR_W(3), .DATA_W(16)) u_dut1 (
    .CLK(clk), .RST(rst), .P_ADDR(p_addr1), .P_DATA(p_data1), .P_ENA(p_ena1),
    .P_RDY(p_rdy1), .TX_CLK(tx_clk1), .TX_DATA(tx_data1), .TX_LOAD(tx_load1),
    .TX_STOP(tx_stop1), .BUSY(busy1), .state_dbg(st1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int fi4   = 0;
  logic [F-1:0] exp_q[$];

  // pin monitor, DUT4: every sample time is the preceding rising CLK edge
  logic [F-1:0] bits4 = '0;
  int           rises4 = 0;
  int           run4 = 0;
  logic         pclk4 = 1'b0, pload4 = 1'b0, pbusy4 = 1'b0;
  time          first4 = 0;
  time          t_busy4 = 0;
  logic [F-1:0] got_bits4[$];
  logic         got_stop4[$];
  int           got_rises4[$];
  int           got_len4[$];
  time          got_tload4[$];
  time          got_tfirst4[$];

  always @(negedge clk) begin
    if (rst) begin
      bits4 = '0; rises4 = 0; run4 = 0;
      pclk4 = 1'b0; pload4 = 1'b0; pbusy4 = 1'b0;
    end else begin
      if (tx_clk4 && !pclk4) begin
        if (rises4 == 0) first4 = $time - 5;
        bits4 = {bits4[F-2:0], tx_data4};
        rises4++;
      end
      if (tx_load4 && !pload4) begin
        got_bits4.push_back(bits4);
        got_stop4.push_back(tx_stop4);
        got_rises4.push_back(rises4);
        got_tload4.push_back($time - 5);
        got_tfirst4.push_back(first4);
        rises4 = 0;
      end
      if (tx_load4) run4++;
      else if (pload4) begin
        got_len4.push_back(run4);
        run4 = 0;
      end
      if (!busy4 && pbusy4) t_busy4 = $time - 5;
      pclk4 = tx_clk4; pload4 = tx_load4; pbusy4 = busy4;
    end
  end

  // pin monitor, DUT1 (single frame)
  logic [F-1:0] bits1 = '0, fbits1 = '0;
  int           rises1 = 0, frises1 = 0, run1 = 0, len1 = 0, nload1 = 0;
  logic         pclk1 = 1'b0, pload1 = 1'b0, pbusy1 = 1'b0, stop1 = 1'b0;
  time          first1 = 0, last1 = 0, t_load1 = 0, t_busy1 = 0;

  always @(negedge clk) begin
    if (rst) begin
      bits1 = '0; rises1 = 0; run1 = 0;
      pclk1 = 1'b0; pload1 = 1'b0; pbusy1 = 1'b0;
    end else begin
      if (tx_clk1 && !pclk1) begin
        if (rises1 == 0) first1 = $time - 5;
        last1 = $time - 5;
        bits1 = {bits1[F-2:0], tx_data1};
        rises1++;
      end
      if (tx_load1 && !pload1) begin
        fbits1 = bits1; frises1 = rises1; stop1 = tx_stop1;
        t_load1 = $time - 5; nload1++; rises1 = 0;
      end
      if (tx_load1) run1++;
      else if (pload1) begin
        len1 = run1;
        run1 = 0;
      end
      if (!busy1 && pbusy1) t_busy1 = $time - 5;
      pclk1 = tx_clk1; pload1 = tx_load1; pbusy1 = busy1;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a falling CLK edge) ----------------
  // Keeps P_ENA high, re-randomising the word every cycle it is refused; the
  // value present on the accepting edge is what the model expects on the wire.
  task automatic send4(input logic [2:0] a, input logic [15:0] d, output time t_acc);
    int n;
    n = 0;
    p_ena4 = 1'b1; p_addr4 = a; p_data4 = d;
    while (!p_rdy4 && n < 400) begin
      @(negedge clk);
      n++;
      p_addr4 = 3'($urandom_range(0, 7));
      p_data4 = 16'($urandom_range(0, 65535));
    end
    check("accept_wait", 32'(p_rdy4), 32'd1);
    exp_q.push_back({p_addr4, p_data4});
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
  endtask

  task automatic release4();
    p_ena4 = 1'b0;
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (busy4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy4), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_frame4(input string tag, input logic exp_stop,
                              output time t_load, output time t_first);
    logic [F-1:0] w;
    t_load = 0; t_first = 0;
    check({tag, "_present"}, 32'(got_bits4.size() > fi4), 32'd1);
    if (got_bits4.size() > fi4 && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, "_bits"},  32'(got_bits4[fi4]), 32'(w));
      check({tag, "_stop"},  32'(got_stop4[fi4]), 32'(exp_stop));
      check({tag, "_rises"}, 32'(got_rises4[fi4]), 32'd19);
      check({tag, "_loadlen"}, (got_len4.size() > fi4) ? 32'(got_len4[fi4]) : 32'hFFFF_FFFF, 32'd8);
      t_load  = got_tload4[fi4];
      t_first = got_tfirst4[fi4];
      fi4++;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    time t_a, t_b, t_c, t_d, t_l, t_l2, t_f;
    int  nframes;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx_clk",  32'(tx_clk4),  32'd0);
    check("rst_tx_data", 32'(tx_data4), 32'd0);
    check("rst_tx_load", 32'(tx_load4), 32'd0);
    check("rst_tx_stop", 32'(tx_stop4), 32'd0);
    check("rst_busy",    32'(busy4),    32'd0);
    check("rst_p_rdy",   32'(p_rdy4),   32'd1);
    #2 rst = 1'b0;
    @(negedge clk);

    // single word: first rise after 1+4 cycles, LOAD after 1+152, idle after 1+168
    send4(3'b101, 16'hA5C3, t_a);
    release4();
    wait_idle4();
    check_frame4("single", 1'b1, t_l, t_f);
    check("single_first_rise", 32'(t_f - t_a), 32'd50);
    check("single_load_at",    32'(t_l - t_a), 32'd1530);
    check("single_busy_fall",  32'(t_busy4 - t_a), 32'd1690);

    // burst of three with P_ENA held high
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_a);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_b);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_c);
    release4();
    check("burst_acc2", 32'(t_b - t_a), 32'd20);
    check("burst_acc3", 32'(t_c - t_a), 32'd1700);
    wait_idle4();
    check_frame4("burst0", 1'b0, t_l, t_f);
    check("burst0_load_at", 32'(t_l - t_a), 32'd1530);
    check_frame4("burst1", 1'b0, t_l2, t_f);
    check("burst_space01", 32'(t_l2 - t_l), 32'd1680);
    check_frame4("burst2", 1'b1, t_l, t_f);
    check("burst_space12", 32'(t_l - t_l2), 32'd1680);

    // late continuation: second word accepted on the LOAD entry edge
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_a);
    release4();
    while ($time < t_a + 1525) @(negedge clk);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_b);
    release4();
    check("late_acc_edge", 32'(t_b - t_a), 32'd1530);
    wait_idle4();
    check_frame4("late0", 1'b0, t_l, t_f);
    check_frame4("late1", 1'b1, t_l2, t_f);
    check("late_space", 32'(t_l2 - t_l), 32'd1680);

    // backpressure: data keeps changing while refused
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_a);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_b);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_c);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_d);
    release4();
    wait_idle4();
    check("bp_frame_count", 32'(got_bits4.size() - fi4), 32'd4);
    check_frame4("bp0", 1'b0, t_l, t_f);
    check_frame4("bp1", 1'b0, t_l, t_f);
    check_frame4("bp2", 1'b0, t_l, t_f);
    check_frame4("bp3", 1'b1, t_l, t_f);

    // CLK_DIV = 1: 2-cycle bit period, 42-cycle frame
    p_ena1 = 1'b1; p_addr1 = 3'd0; p_data1 = 16'hFFFF;
    check("div1_rdy", 32'(p_rdy1), 32'd1);
    @(posedge clk);
    t_a = $time;
    @(negedge clk);
    p_ena1 = 1'b0;
    begin
      int n;
      n = 0;
      while (busy1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("div1_idle", 32'(busy1), 32'd0);
    @(negedge clk);
    check("div1_nload",      32'(nload1),  32'd1);
    check("div1_bits",       32'(fbits1),  32'({3'd0, 16'hFFFF}));
    check("div1_rises",      32'(frises1), 32'd19);
    check("div1_first_rise", 32'(first1 - t_a), 32'd20);
    check("div1_rise_span",  32'(last1 - first1), 32'd360);
    check("div1_load_at",    32'(t_load1 - t_a), 32'd390);
    check("div1_loadlen",    32'(len1), 32'd2);
    check("div1_stop",       32'(stop1), 32'd1);
    check("div1_busy_fall",  32'(t_busy1 - t_a), 32'd430);

    // reset during bit 10 with a second word held
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_a);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_b);
    release4();
    while ($time < t_a + 855) @(negedge clk);
    check("mid_busy",   32'(busy4),   32'd1);
    check("mid_rdy",    32'(p_rdy4),  32'd0);
    check("mid_tx_clk", 32'(tx_clk4), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_tx_clk",  32'(tx_clk4),  32'd0);
    check("async_tx_data", 32'(tx_data4), 32'd0);
    check("async_tx_load", 32'(tx_load4), 32'd0);
    check("async_tx_stop", 32'(tx_stop4), 32'd0);
    check("async_busy",    32'(busy4),    32'd0);
    check("async_rdy",     32'(p_rdy4),   32'd1);
    exp_q.delete();
    nframes = got_bits4.size();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (200) @(negedge clk);
    check("post_rst_rises",  32'(rises4), 32'd0);
    check("post_rst_frames", 32'(got_bits4.size()), 32'(nframes));
    check("post_rst_busy",   32'(busy4),  32'd0);
    check("post_rst_rdy",    32'(p_rdy4), 32'd1);
    send4(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), t_a);
    release4();
    wait_idle4();
    check_frame4("post_rst", 1'b1, t_l, t_f);
    check("post_rst_load_at", 32'(t_l - t_a), 32'd1530);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial transmitter for the four-wire board link (CLK/DATA/LOAD/STOP). It is the transmit counterpart of `deserializer`. It accepts 3-bit address + 16-bit data words over a valid/ready handshake and shifts them out MSB-first. After each word it emits a LOAD strobe, and it flags the last word of a burst with STOP. It drives the TX_CLK0/TX_DATA0/TX_LOAD0/TX_STOP0 pins of the top level.

## Interface
- CLK_DIV, 4: TX_CLK half-period in CLK cycles; legal values ≥ 1.
- ADDR_W, 3: address field width.
- DATA_W, 16: data field width. Frame length F = ADDR_W + DATA_W (19 by default).

Ports:
- CLK  in  1  system clock; the block uses one clock.
- RST  in  1  reset, asynchronous, active-high.
- P_ADDR  in  ADDR_W  word address.
- P_DATA  in  DATA_W  word data.
- P_ENA  in  1  word valid.
- P_RDY  out  1  ready; a word is accepted on a CLK edge where P_ENA & P_RDY.
- TX_CLK  out  1  serial clock, idles low.
- TX_DATA  out  1  serial data, changes only while TX_CLK is low.
- TX_LOAD  out  1  end-of-word strobe.
- TX_STOP  out  1  end-of-burst flag, asserted together with TX_LOAD.
- BUSY  out  1  high while the state is not IDLE or the holding register is full.

## Operation
- Two-stage buffer: holding register (hold, hold_valid) feeds the shift register.
- P_RDY = !hold_valid. An accepted word is written to hold.
- FSM states:
  - IDLE: TX_CLK=0, TX_DATA=0. If hold_valid: load shifter = {P_ADDR,P_DATA} from hold, clear hold_valid, go to SHIFT.
  - SHIFT: F bit periods. Each bit period is 2·CLK_DIV cycles: CLK_DIV cycles TX_CLK low, then CLK_DIV cycles TX_CLK high. TX_DATA = shifter MSB. The shifter shifts left on the last high cycle of each bit. After bit F−1, go to LOAD.
  - LOAD: one bit period. TX_CLK stays low, TX_LOAD=1. TX_STOP=1 iff, on the entry edge, hold_valid=0 and no word is being accepted. After LOAD, go to GAP.
  - GAP: one bit period with all outputs low. Then go to IDLE, or, if hold_valid, load the shifter directly and go to SHIFT with no extra cycle.
- Bit counter width is ceil(log2(F+1)). The divider counter counts 0..CLK_DIV−1 and wraps.
- A word arriving on the same edge as LOAD entry counts as a continuation: TX_STOP=0.
- When hold is full, P_RDY=0 and P_ENA is ignored; no data is lost or overwritten.

## Timing
- All outputs are registered except P_RDY, which is a direct function of hold_valid.
- Reset values: TX_CLK=0, TX_DATA=0, TX_LOAD=0, TX_STOP=0, BUSY=0, hold_valid=0 (so P_RDY=1), state IDLE.
- Latency from IDLE:
  - Word accepted at edge E0.
  - Shifter loads at E1: TX_DATA = addr MSB, TX_CLK low.
  - First TX_CLK rise at E1+CLK_DIV.
- Per-word period is (F+2)·2·CLK_DIV cycles; 168 cycles with defaults. Back-to-back words stream with no idle gap beyond GAP.
- The receiver samples on the TX_CLK rising edge. TX_DATA is stable for CLK_DIV cycles before and CLK_DIV cycles after each rise.
- P_RDY rises on the cycle after the shifter takes the hold word. A second word can therefore be accepted during SHIFT of the first.
- RST asserted mid-frame drives all outputs low immediately and discards both the shifter and hold contents. No partial LOAD is emitted.

## Test plan
- Single word, CLK_DIV=4, addr=3'b101, data=16'hA5C3. Required response:
  - 19 rising TX_CLK edges sampling 1,0,1 then A5C3 MSB-first.
  - TX_LOAD=1 and TX_STOP=1 for 8 cycles.
  - BUSY low 168 cycles after acceptance.
- Burst of 3 words with P_ENA held high, driven as fast as P_RDY allows. Required response:
  - Frames back-to-back, 168 cycles apart.
  - TX_STOP=0 on the first two LOADs and 1 on the third.
  - P_RDY low only while hold is full.
- Late continuation: present word 2 exactly on the LOAD-entry edge of word 1. Required response: TX_STOP=0 on word 1's LOAD, and word 2 is transmitted after GAP.
- Backpressure: hold P_ENA high with changing data while P_RDY=0. Required response: only values present on accepting edges are transmitted, in order, with none duplicated.
- CLK_DIV=1, data=16'hFFFF, addr=0. Required response: 2-cycle bit period, 42-cycle frame, bits correct.
- Assert RST during bit 10 of a frame with another word held. Required response: outputs go to 0 asynchronously. After release, P_RDY=1, BUSY=0, and no TX_CLK activity until a new word is accepted.
